hazard_trace_buffer: RTL
========================

# hazard_trace_buffer

Synthesizable pipeline-hazard tracer for the 5-stage 16-bit WISC pipeline. It samples the stall, flush and hazard-type signals every cycle and classifies each active cycle by cause. Each event is logged as a record in a parametrised circular buffer that is drained by a simple read handshake. Saturating per-cause counters are kept alongside the buffer, so long runs can be profiled in silicon or in simulation without string-based display code.

## Interface
- `DEPTH`, 8: buffer entries; power of 2, ≥2.
- `PC_W`, 16: width of the logged PC.
- `CNT_W`, 16: width of every statistics counter.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `pc_stall`, `if_id_stall`, `if_flush`, `id_flush` in 1 each: pipeline control.
- `load_use_hazard`, `br_hazard`, `b_hazard`, `hlt` in 1 each: hazard type.
- `pc_id` in PC_W: PC of the instruction in ID.
- `opcode_id` in 4: opcode in ID.
- `clr` in 1: synchronous clear of buffer, counters and `overflow`.
- `rd_en` in 1: pop request.
- `rd_vld` out 1: `rd_data` holds a popped record.
- `rd_data` out REC_W: record.
- `empty`, `full` out 1: buffer status.
- `level` out $clog2(DEPTH)+1: entries held.
- `overflow` out 1: sticky, set when any event is dropped.
- `stall_cnt`, `flush_cnt`, `lu_cnt`, `br_cnt`, `b_cnt`, `hlt_cnt`, `drop_cnt` out CNT_W each.

## Operation
- Event cycle: `pc_stall | if_id_stall | if_flush | id_flush`.
- Cause priority: load_use=1 > br=2 > b=3 > hlt=4; none=0.
- If `if_flush` is high, cause=5 (mispredict) overrides the priority above.
- Record layout, MSB→LSB: `{[rpt(4)], cause(3), flags(4)={pc_stall,if_id_stall,if_flush,id_flush}, opcode_id(4), pc_id}`.
- REC_W = 11+PC_W, plus 4 when the repeat field is compiled in.
- Push on an event cycle when not full.
- Event while full and no pop in the same cycle: record dropped, `overflow`←1, `drop_cnt`+1.
- Push and pop in the same cycle while full: both are accepted and `level` is unchanged.
- Pop when empty: ignored, `rd_vld`=0 next cycle.
- Push and pop in the same cycle while empty: the push is accepted and the pop is ignored.
- Pointers wrap modulo DEPTH.
- Counter updates per event cycle:
  - `stall_cnt`+1 if `pc_stall|if_id_stall`.
  - `flush_cnt`+1 if `if_flush|id_flush`.
  - Exactly one of the cause counters +1. Cause 5 counts in `flush_cnt` only.
  - Cause 0 events, i.e. a stall with no type signal, are logged but counted only in stall/flush.
- All counters saturate at all-ones.
- `clr` and reset both zero: pointers, `level`, counters, `overflow`, `rd_vld`, `rd_data`.
- `clr` wins over a push or pop in the same cycle.

## Timing
- Inputs are sampled at the edge. Push, counters and `level` are visible the cycle after the event.
- Read latency is 1: `rd_en` with non-empty at edge N gives `rd_vld`=1 and `rd_data` valid after edge N.
- `rd_vld` is a single-cycle pulse per pop. `rd_data` holds until the next pop.
- Back-to-back pops give one record per cycle.
- Reset values:
  - All outputs 0, except `empty`=1.
  - Reset applied mid-run discards all contents the following cycle.

## Configuration
- `TRACE_COALESCE_EN` defined:
  - Record has a 4-bit `rpt` field (occurrences−1).
  - A coalesce occurs when all hold: the event matches the last pushed {cause, flags, opcode, pc}; the previous cycle was an event cycle; the buffer is non-empty; `rpt`<15; and the tail entry is not popped in the same cycle (i.e. not level==1 with pop).
  - On a coalesce, the tail `rpt` increments in place instead of pushing, and counters still increment.
  - When `rpt` reaches 15, the next match pushes a new record.
- Not defined: no `rpt` field, and every event cycle pushes.

## Structure
- `trace_pkg` holds:
  - the `cause_t` enum (NONE, LOAD_USE, BR, B, HLT, MISPRED);
  - the field-width localparams;
  - a `decode_cause` function implementing the priority above.
- Sub-module `trace_fifo`: parametrised synchronous FIFO (DEPTH, width) with tail-write port for coalescing. The top level holds classification, counters and overflow.

## Test plan
- Reset, then 3 cycles of `load_use_hazard`+`pc_stall`+`if_id_stall`, pc=0x0010, op=0x8:
  - Without macro: level=3, `lu_cnt`=3, `stall_cnt`=3.
  - With macro: level=1, rpt=2.
- `if_flush`+`id_flush`+`b_hazard`: record cause=5, `flush_cnt`=1, `b_cnt`=0.
- 9 events at DEPTH=8 with no reads: `full`=1, `drop_cnt`=1, `overflow`=1. Then 8 pops give 8 records in order, then `empty`=1.
- Full buffer with an event and `rd_en` in the same cycle: level stays 8, no drop, the oldest record is returned next cycle.
- CNT_W=4 with 20 `br_hazard` stall cycles: `br_cnt`=15 (saturated). Then `clr`: all counters 0, `empty`=1.
- `rst_n`=0 for one cycle with 5 entries held: level=0, `rd_vld`=0. A following `rd_en` gives no `rd_vld`.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - cause encoding, field widths and cause decoder for the hazard tracer (optional macro TRACE_COALESCE_EN)
package trace_pkg;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    LOAD_USE = 3'd1,
    BR       = 3'd2,
    B        = 3'd3,
    HLT      = 3'd4,
    MISPRED  = 3'd5
  } cause_t;

  localparam int CAUSE_W = 3;
  localparam int FLAGS_W = 4;
  localparam int OP_W    = 4;
  localparam int RPT_W   = 4;
  localparam logic [RPT_W-1:0] RPT_MAX = 4'hF;

`ifdef TRACE_COALESCE_EN
  localparam int RPT_FIELD_W = RPT_W;
`else
  localparam int RPT_FIELD_W = 0;
`endif

  // A fetch flush means a mispredict regardless of which hazard type is also raised.
  function automatic cause_t decode_cause(input logic if_flush, input logic lu,
                                          input logic br_h, input logic b_h,
                                          input logic hlt_h);
    if (if_flush)   return MISPRED;
    else if (lu)    return LOAD_USE;
    else if (br_h)  return BR;
    else if (b_h)   return B;
    else if (hlt_h) return HLT;
    else            return NONE;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous circular record FIFO with in-place tail rewrite
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 27,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  input  logic             tail_wr,
  input  logic [W-1:0]     tail_wdata,
  output logic [W-1:0]     tail_data,
  output logic             rd_vld,
  output logic [W-1:0]     rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_vld_q, rd_vld_d;
  logic [W-1:0]     rd_data_q, rd_data_d;
  logic             pop_ok, push_ok;
  logic [AW-1:0]    tail_idx;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign level    = level_q;
  assign rd_vld   = rd_vld_q;
  assign rd_data  = rd_data_q;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign tail_idx = wr_ptr_q - 1'b1;
  assign tail_data = mem_q[tail_idx];

  // Next pointer, level and read-port state; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    rd_vld_d  = pop_ok;
    rd_data_d = rd_data_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
  end

  // Control state register; clear beats any push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Record storage: normal push or rewrite of the newest entry.
  always_ff @(posedge clk) begin
    if (rst_n && !clr) begin
      if (push_ok)      mem_q[wr_ptr_q] <= wdata;
      else if (tail_wr) mem_q[tail_idx] <= tail_wdata;
    end
  end

endmodule

// File: rtl/hazard_trace_buffer.sv
// rtl/hazard_trace_buffer.sv - pipeline hazard classifier, trace buffer and saturating counters (optional macro TRACE_COALESCE_EN)
module hazard_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 16,
  parameter int CNT_W = 16,
  localparam int BODY_W = CAUSE_W + FLAGS_W + OP_W + PC_W,
  localparam int REC_W  = RPT_FIELD_W + BODY_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_stall,
  input  logic             if_id_stall,
  input  logic             if_flush,
  input  logic             id_flush,
  input  logic             load_use_hazard,
  input  logic             br_hazard,
  input  logic             b_hazard,
  input  logic             hlt,
  input  logic [PC_W-1:0]  pc_id,
  input  logic [3:0]       opcode_id,
  input  logic             clr,
  input  logic             rd_en,
  output logic             rd_vld,
  output logic [REC_W-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] hlt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              ev, is_stall, is_flush, push_req, drop;
  cause_t            cause;
  logic [BODY_W-1:0] body;
  logic [REC_W-1:0]  wdata, tail_data, tail_wdata;
  logic              tail_wr;

  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, lu_q, lu_d, br_q, br_d;
  logic [CNT_W-1:0] b_q, b_d, hlt_q, hlt_d, drop_q, drop_d;
  logic             ovf_q, ovf_d;

  assign is_stall = pc_stall | if_id_stall;
  assign is_flush = if_flush | id_flush;
  assign ev       = is_stall | is_flush;
  assign cause    = decode_cause(if_flush, load_use_hazard, br_hazard, b_hazard, hlt);
  assign body     = {cause, pc_stall, if_id_stall, if_flush, id_flush, opcode_id, pc_id};
  // Dropped when the buffer is full and nothing leaves this cycle.
  assign drop     = push_req & full & ~rd_en;

`ifdef TRACE_COALESCE_EN
  logic             ev_q;
  logic             coalesce;
  logic [RPT_W-1:0] tail_rpt;

  assign tail_rpt = tail_data[REC_W-1 -: RPT_W];
  // Repeat of the newest record, unless that record is leaving right now.
  assign coalesce = ev & ev_q & ~empty & (tail_data[BODY_W-1:0] == body) &
                    (tail_rpt != RPT_MAX) & ~((level == LVL_W'(1)) & rd_en);
  assign push_req   = ev & ~coalesce;
  assign wdata      = {{RPT_W{1'b0}}, body};
  assign tail_wr    = coalesce;
  assign tail_wdata = {tail_rpt + 1'b1, tail_data[BODY_W-1:0]};

  // Remember whether the previous cycle was an event cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) ev_q <= 1'b0;
    else               ev_q <= ev;
  end
`else
  assign push_req   = ev;
  assign wdata      = body;
  assign tail_wr    = 1'b0;
  assign tail_wdata = tail_data;
`endif

  trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .push       (push_req),
    .wdata      (wdata),
    .pop        (rd_en),
    .tail_wr    (tail_wr),
    .tail_wdata (tail_wdata),
    .tail_data  (tail_data),
    .rd_vld     (rd_vld),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .level      (level)
  );

  // Per-cause statistics; mispredicts and cause-less stalls touch only stall/flush.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    lu_d    = lu_q;
    br_d    = br_q;
    b_d     = b_q;
    hlt_d   = hlt_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (ev) begin
      if (is_stall) stall_d = sat_inc(stall_q);
      if (is_flush) flush_d = sat_inc(flush_q);
      case (cause)
        LOAD_USE: lu_d  = sat_inc(lu_q);
        BR:       br_d  = sat_inc(br_q);
        B:        b_d   = sat_inc(b_q);
        HLT:      hlt_d = sat_inc(hlt_q);
        default:  ;
      endcase
    end
    if (drop) begin
      drop_d = sat_inc(drop_q);
      ovf_d  = 1'b1;
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
      br_q    <= '0;
      b_q     <= '0;
      hlt_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      lu_q    <= lu_d;
      br_q    <= br_d;
      b_q     <= b_d;
      hlt_q   <= hlt_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign lu_cnt    = lu_q;
  assign br_cnt    = br_q;
  assign b_cnt     = b_q;
  assign hlt_cnt   = hlt_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;

endmodule
